hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, memory-wait, branch/jump and halt
// requests into per-stage load enables and bubble flushes, with stall/flush statistics.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        Need_Stall,
  input  logic        EXmem__MemBusy,
  input  logic        EX__BranchTaken,
  input  logic        ID__Jump,
  input  logic        Halt,
  output logic        PC_En,
  output logic        IFid_En,
  output logic        IDex_En,
  output logic        EXmem_En,
  output logic        MEMwb_En,
  output logic        IFid_Flush,
  output logic        IDex_Flush,
  output logic        MEMwb_Flush,
  output logic        Halted,
  output logic        Mem_Timeout,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
);

  // state   | meaning
  // RUN     | normal issue, hazards resolved by priority
  // MEMWAIT | memory stage busy, pipeline frozen
  // DRAIN   | halt seen, fetch stopped while in-flight work retires
  // HALTED  | pipeline stopped until reset
  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic [7:0]  wait_q, wait_d;
  logic        bubble_q, bubble_d;
  logic        tmo_q, tmo_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        stall_ev, flush_ev;

  always_comb begin
    PC_En       = 1'b1;
    IFid_En     = 1'b1;
    IDex_En     = 1'b1;
    EXmem_En    = 1'b1;
    MEMwb_En    = 1'b1;
    IFid_Flush  = 1'b0;
    IDex_Flush  = 1'b0;
    MEMwb_Flush = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    wait_d      = 8'd0;
    bubble_d    = 1'b0;
    tmo_d       = tmo_q;
    halted_d    = halted_q;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (!rst) begin
      case (state_q)
        HALTED: begin
          PC_En    = 1'b0;
          IFid_En  = 1'b0;
          IDex_En  = 1'b0;
          EXmem_En = 1'b0;
          MEMwb_En = 1'b0;
        end
        default: begin
          if (EXmem__MemBusy) begin
            PC_En       = 1'b0;
            IFid_En     = 1'b0;
            IDex_En     = 1'b0;
            EXmem_En    = 1'b0;
            MEMwb_Flush = 1'b1;
            stall_ev    = 1'b1;
            if (wait_q == 8'hFF) begin
              wait_d = wait_q;
              tmo_d  = 1'b1;
            end else begin
              wait_d = wait_q + 8'd1;
            end
            // a busy memory only freezes the drain, it does not abandon it
            if (state_q != DRAIN) state_d = MEMWAIT;
          end else if (state_q == DRAIN) begin
            PC_En      = 1'b0;
            IFid_Flush = 1'b1;
            if (drain_q == 3'd0) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              drain_d = drain_q - 3'd1;
            end
          end else begin
            state_d = RUN;
            if (EX__BranchTaken) begin
              IFid_Flush = 1'b1;
              IDex_Flush = 1'b1;
              flush_ev   = 1'b1;
            end else if (ID__Jump) begin
              IFid_Flush = 1'b1;
              flush_ev   = 1'b1;
            end else if (Need_Stall && !bubble_q) begin
              PC_En      = 1'b0;
              IFid_En    = 1'b0;
              IDex_Flush = 1'b1;
              stall_ev   = 1'b1;
              bubble_d   = 1'b1;
            end else if (Halt) begin
              state_d = DRAIN;
              drain_d = 3'd3;
            end
          end
        end
      endcase
    end
    stall_cnt_d = (stall_ev && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush_ev && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= 3'd0;
      wait_q      <= 8'd0;
      bubble_q    <= 1'b0;
      tmo_q       <= 1'b0;
      halted_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wait_q      <= wait_d;
      bubble_q    <= bubble_d;
      tmo_q       <= tmo_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Halted      = halted_q;
  assign Mem_Timeout = tmo_q;
  assign Stall_Cnt   = stall_cnt_q;
  assign Flush_Cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level behavioural model predicts each
// cycle's enables/flushes and counters; a monitor pops and compares at the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        need = 1'b0, mbusy = 1'b0, br = 1'b0, jmp = 1'b0, hlt = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_fl, idex_fl, memwb_fl, halted, tmo;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .Need_Stall(need), .EXmem__MemBusy(mbusy),
    .EX__BranchTaken(br), .ID__Jump(jmp), .Halt(hlt),
    .PC_En(pc_en), .IFid_En(ifid_en), .IDex_En(idex_en), .EXmem_En(exmem_en),
    .MEMwb_En(memwb_en), .IFid_Flush(ifid_fl), .IDex_Flush(idex_fl),
    .MEMwb_Flush(memwb_fl), .Halted(halted), .Mem_Timeout(tmo),
    .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {PC, IFid, IDex, EXmem, MEMwb enables, IFid, IDex, MEMwb flushes}
  typedef struct packed {
    logic [7:0]  ctl;
    logic        halted;
    logic        tmo;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // model state: plain counts rather than an encoded FSM
  bit m_halted, m_bubble, m_tmo;
  int m_drain_left, m_busy_run, m_sc, m_fc;

  function automatic void model_reset();
    m_halted = 0; m_bubble = 0; m_tmo = 0;
    m_drain_left = 0; m_busy_run = 0; m_sc = 0; m_fc = 0;
  endfunction

  task automatic cyc(input bit r, input bit ns, input bit mb, input bit b,
                     input bit j, input bit h);
    exp_t e;
    bit   stalled;
    @(posedge clk);
    #1;
    rst = r; need = ns; mbusy = mb; br = b; jmp = j; hlt = h;
    if (r) begin
      model_reset();
      e = '{ctl: 8'b11111_000, halted: 1'b0, tmo: 1'b0, sc: 16'd0, fc: 16'd0};
      q.push_back(e);
      return;
    end
    e.halted = m_halted;
    e.tmo    = m_tmo;
    e.sc     = 16'(m_sc);
    e.fc     = 16'(m_fc);
    stalled  = 0;
    if (m_halted) begin
      e.ctl = 8'b00000_000;
    end else if (mb) begin
      e.ctl = 8'b00001_001;
      m_busy_run++;
      if (m_busy_run >= 256) m_tmo = 1;
      if (m_sc < 65535) m_sc++;
    end else if (m_drain_left > 0) begin
      e.ctl = 8'b01111_100;
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (b) begin
      e.ctl = 8'b11111_110;
      if (m_fc < 65535) m_fc++;
    end else if (j) begin
      e.ctl = 8'b11111_100;
      if (m_fc < 65535) m_fc++;
    end else if (ns && !m_bubble) begin
      e.ctl = 8'b00111_010;
      stalled = 1;
      if (m_sc < 65535) m_sc++;
    end else begin
      e.ctl = 8'b11111_000;
      if (h) m_drain_left = 4;
    end
    if (!mb) m_busy_run = 0;
    m_bubble = stalled;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [7:0] ctl;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl};
        n_vec++;
        if (ctl !== e.ctl) begin
          n_err++;
          $display("FAIL ctl t=%0t got %b exp %b", $time, ctl, e.ctl);
        end
        if (halted !== e.halted) begin
          n_err++;
          $display("FAIL halted t=%0t got %b exp %b", $time, halted, e.halted);
        end
        if (tmo !== e.tmo) begin
          n_err++;
          $display("FAIL mem_timeout t=%0t got %b exp %b", $time, tmo, e.tmo);
        end
        if (stall_cnt !== e.sc) begin
          n_err++;
          $display("FAIL stall_cnt t=%0t got %h exp %h", $time, stall_cnt, e.sc);
        end
        if (flush_cnt !== e.fc) begin
          n_err++;
          $display("FAIL flush_cnt t=%0t got %h exp %h", $time, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    cyc(1, 1, 1, 1, 1, 1);
    cyc(1, 1, 0, 0, 0, 0);
    idle(2);
    // load-use held three cycles: stall, normal, stall
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    idle(2);
    // branch wins over load-use
    cyc(0, 1, 0, 1, 0, 0);
    idle(2);
    // memory wait alongside a held jump
    repeat (5) cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    // 256-cycle memory wait trips the sticky timeout
    repeat (256) cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0);
    // halt with two busy cycles inside the drain
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0, 0);
    idle(5);
    repeat (6) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
    cyc(1, 0, 0, 0, 0, 0);
    // reset aborts a drain
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(6);
    // saturate the stall counter, then one more load-use stall
    repeat (65535) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    idle(3);
    // random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 3);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
